// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns engine: one shared column datapath, four compute cycles per block.
// Optional MIXCOL_DUAL_EN adds an `inv` input selecting InvMixColumns, latched at accept.
//
// state | meaning
// IDLE  | ready for a new block
// CALC  | transforming column r_col of the working register
// DONE  | result presented, waiting for out_ready
module mix_columns_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
`ifdef MIXCOL_DUAL_EN
   ,
   input  logic         inv
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_col;
   logic [127:0]  r_work;
   logic [31:0]   w_col_in, w_col_out;
   logic          w_accept;
`ifdef MIXCOL_DUAL_EN
   logic          r_inv;
`endif

   function automatic logic [7:0] f_xt(input logic [7:0] b);
      f_xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] f_row(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
      f_row = f_xt(b0) ^ (f_xt(b1) ^ b1) ^ b2 ^ b3;
   endfunction

`ifdef MIXCOL_DUAL_EN
   // 0E.b0 ^ 0B.b1 ^ 0D.b2 ^ 09.b3, each multiple composed from x2/x4/x8 of the byte
   function automatic logic [7:0] f_irow(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] a2, a4, a8, c2, c8, d4, d8, e8;
      a2 = f_xt(b0); a4 = f_xt(a2); a8 = f_xt(a4);
      c2 = f_xt(b1); c8 = f_xt(f_xt(c2));
      d4 = f_xt(f_xt(b2)); d8 = f_xt(d4);
      e8 = f_xt(f_xt(f_xt(b3)));
      f_irow = (a8 ^ a4 ^ a2) ^ (c8 ^ c2 ^ b1) ^ (d8 ^ d4 ^ b2) ^ (e8 ^ b3);
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: if (r_col == 2'd3) w_state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_col)
         2'd0:    w_col_in = r_work[127:96];
         2'd1:    w_col_in = r_work[95:64];
         2'd2:    w_col_in = r_work[63:32];
         default: w_col_in = r_work[31:0];
      endcase
   end

   always_comb begin
      w_col_out = {f_row(w_col_in[31:24], w_col_in[23:16], w_col_in[15:8],  w_col_in[7:0]),
                   f_row(w_col_in[23:16], w_col_in[15:8],  w_col_in[7:0],   w_col_in[31:24]),
                   f_row(w_col_in[15:8],  w_col_in[7:0],   w_col_in[31:24], w_col_in[23:16]),
                   f_row(w_col_in[7:0],   w_col_in[31:24], w_col_in[23:16], w_col_in[15:8])};
`ifdef MIXCOL_DUAL_EN
      if (r_inv)
         w_col_out = {f_irow(w_col_in[31:24], w_col_in[23:16], w_col_in[15:8],  w_col_in[7:0]),
                      f_irow(w_col_in[23:16], w_col_in[15:8],  w_col_in[7:0],   w_col_in[31:24]),
                      f_irow(w_col_in[15:8],  w_col_in[7:0],   w_col_in[31:24], w_col_in[23:16]),
                      f_irow(w_col_in[7:0],   w_col_in[31:24], w_col_in[23:16], w_col_in[15:8])};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work <= '0;
         r_col  <= 2'd0;
`ifdef MIXCOL_DUAL_EN
         r_inv  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_work <= in_data;
         r_col  <= 2'd0;
`ifdef MIXCOL_DUAL_EN
         r_inv  <= inv;
`endif
      end else if (r_state == S_CALC) begin
         case (r_col)
            2'd0:    r_work[127:96] <= w_col_out;
            2'd1:    r_work[95:64]  <= w_col_out;
            2'd2:    r_work[63:32]  <= w_col_out;
            default: r_work[31:0]   <= w_col_out;
         endcase
         r_col <= r_col + 2'd1;
      end
   end

   assign out_data = r_work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: directed vectors, backpressure, back-to-back, async reset.
module tb_mix_columns_seq;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_ready, out_valid;
   logic [127:0] out_data;
`ifdef MIXCOL_DUAL_EN
   logic         inv_drv = 1'b0;
`endif

   mix_columns_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MIXCOL_DUAL_EN
      , .inv(inv_drv)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
   localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
   localparam logic [127:0] VC = 128'hf20a225c_db135345_d4d4d4d5_2d26314c;
   localparam logic [127:0] EC = 128'h9fdc589d_8e4da1bc_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] VD = 128'h2d26314c_ffffffff_db135345_00000000;
   localparam logic [127:0] ED = 128'h4d7ebdf8_ffffffff_8e4da1bc_00000000;

   int           cyc = 0;
   logic [127:0] sb[$];
   int           acc_edges[$];
   int           rise_edge = -1;
   logic         prev_valid = 1'b0;
   int           n_both = 0;
   int           n_checks = 0;
   int           n_pass = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // Monitor: records accepts and valid rise edges, compares every output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) acc_edges.push_back(cyc + 1);
         if (in_ready && out_valid) n_both++;
         if (out_valid && !prev_valid) rise_edge = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
               chk("result", out_data, sb.pop_front());
            end
         end
      end
      prev_valid = out_valid;
   end

   task automatic issue(input logic [127:0] d, input logic [127:0] e, input bit keep);
      int t;
      t = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         fail("accept_timeout");
         in_valid = 1'b0;
      end else begin
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (!keep) in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_valid) && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0 || out_valid) fail(name);
      @(posedge clk);
      #1;
   endtask

`ifdef MIXCOL_DUAL_EN
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] mc_fwd(input logic [127:0] x);
      logic [7:0]   base[4];
      logic [127:0] y;
      logic [7:0]   acc;
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gm(base[(k - r + 4) % 4], x[127 - 32*c - 8*k -: 8]);
            y[127 - 32*c - 8*r -: 8] = acc;
         end
      return y;
   endfunction
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_acc;
      int t;
      #1 rst = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_out_data", out_data, 128'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // FIPS-197 vector and latency
      out_ready = 1'b1;
      issue(V1, E1, 1'b0);
      drain("fips_drain");
      chk("latency", 128'(rise_edge - acc_edges[acc_edges.size()-1]), 128'd4);

      issue(V2, E2, 1'b0);
      drain("vec2_drain");

      // Backpressure in DONE
      out_ready = 1'b0;
      issue(V2, E2, 1'b0);
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) fail("bp_wait_valid");
      n_acc = acc_edges.size();
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) begin
            in_valid = 1'b1;
            in_data  = V1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk("bp_data", out_data, E2);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         chk("bp_out_valid", 128'(out_valid), 128'd1);
      end
      chk("bp_no_accept", 128'(acc_edges.size()), 128'(n_acc));
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain("bp_drain");

      // Back-to-back with in_valid held high
      issue(VC, EC, 1'b1);
      issue(VD, ED, 1'b0);
      drain("b2b_drain");
      chk("b2b_spacing",
          128'(acc_edges[acc_edges.size()-1] - acc_edges[acc_edges.size()-2]), 128'd6);

      // Async reset two cycles after accept
      issue(V1, E1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_data", out_data, 128'd0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      issue(V2, E2, 1'b0);
      drain("post_rst_drain");

`ifdef MIXCOL_DUAL_EN
      inv_drv = 1'b1;
      issue(E1, V1, 1'b0);
      drain("inv_fips_drain");
      for (int i = 0; i < 16; i++) begin
         logic [127:0] x, y;
         x = {$urandom, $urandom, $urandom, $urandom};
         y = mc_fwd(x);
         inv_drv = 1'b0;
         issue(x, y, 1'b0);
         drain("rt_fwd_drain");
         inv_drv = 1'b1;
         issue(y, x, 1'b0);
         drain("rt_inv_drain");
      end
      inv_drv = 1'b0;
`endif

      chk("never_both_ready_valid", 128'(n_both), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
